mult_post: RTL and testbench
============================

Name: mult_post

Overview:
- Result back-end for the shift-add multiplier chain.
- Sits directly downstream of the last multiplier cell and consumes that cell's valid and 2*XLEN+1-bit accumulator.
- Carries per-op sideband (negate, high/low select, tag) through a delay line matched to the chain latency, then applies two's-complement sign fix-up and selects the result half.
- Buffers results in a FIFO with valid/ready output; a credit counter tells the issuer when it may start a new op, because the chain itself has no backpressure.

Parameters:
XLEN, 32, operand width; the cell accumulator is 2*XLEN+1 bits.
LAT, 32, chain latency in cycles from issue to the last cell's valid output (equals the number of cells).
DEPTH, 4, result FIFO entries; also the maximum number of ops in flight plus buffered.
TAGW, 5, destination tag width.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
flush_i  in  1  synchronous flush; asserted in the same cycle as the chain flush
issue_i  in  1  an op enters the first cell this cycle (same cycle as that cell's enable)
neg_i  in  1  final product must be negated (operand signs differ on signed variants)
hi_i  in  1  return bits [2*XLEN-1:XLEN] instead of [XLEN-1:0]
tag_i  in  TAGW  destination tag
issue_ok_o  out  1  a credit is available; the issuer may assert issue_i
cell_valid_i  in  1  last cell ready_o
cell_acc_i  in  2*XLEN+1  last cell acc_o
res_valid_o  out  1  FIFO non-empty
res_ready_i  in  1  consumer accepts the head entry
res_data_o  out  XLEN  head result
res_tag_o  out  TAGW  head tag
err_o  out  1  sticky protocol error

Behaviour:
- Reset (async assert, sync release) clears:
  - delay line valid bits, FIFO pointers, credit counter and err_o;
  - res_valid_o=0, res_data_o=0, res_tag_o=0, issue_ok_o=1 while in reset.
- Delay line: LAT-stage shift register of {v, neg, hi, tag}.
  - Stage 0 loads {issue_i accepted, neg_i, hi_i, tag_i} every cycle.
  - The entry from an issue in cycle T reaches the head in cycle T+LAT, aligned with cell_valid_i.
- Issue acceptance: issue_i is accepted only when issue_ok_o=1.
  - If issue_i=1 while issue_ok_o=0, the op is dropped (v=0 loaded) and err_o is set.
- Result path, in a head cycle with v=1:
  - P = cell_acc_i[2*XLEN-1:0]; bit 2*XLEN is ignored.
  - R = neg ? (~P + 1) mod 2^(2*XLEN) : P.
  - The selected half of R plus the tag is written into the FIFO at that clock edge.
  - Latency: issue at T, res_valid_o at T+LAT+1 when the FIFO was empty.
- Alignment check: if the head v differs from cell_valid_i, err_o is set.
  - Writes follow the head v only; cell_valid_i without a head entry is discarded.
- FIFO:
  - Registered, first-word fall-through; res_valid_o = not empty.
  - Pop occurs on res_valid_o && res_ready_i; outputs hold while not ready.
  - Never overflows, by construction of the credit counter.
- Credits:
  - cnt counts in-flight plus buffered ops, range 0..DEPTH.
  - +1 on accepted issue, -1 on pop; both in one cycle leaves cnt unchanged.
  - issue_ok_o = (cnt < DEPTH), combinational from the registered cnt.
  - A pop in the cycle cnt==DEPTH raises issue_ok_o the next cycle.
- Flush:
  - Clears delay line valids, FIFO and cnt at the next edge.
  - Has priority over issue, pop and write in the same cycle.
  - err_o is not cleared.
  - res_valid_o=0 and issue_ok_o=1 in the following cycle.
- err_o is cleared only by reset.
- Boundaries:
  - Negating zero yields zero.
  - The full 2*XLEN negate carry must propagate into the high half.

Decomposition:
- mult_pkg:
  - XLEN and TAGW defaults;
  - sideband struct {v, neg, hi, tag};
  - function twos_neg(P) over 2*XLEN bits.
- Sub-module mult_post_fifo: generic DEPTH x (XLEN+TAGW) sync FIFO with push/pop/empty and flush.
- Delay line, fix-up and credit logic stay in mult_post.

Test Plan:
- Basic path: cell product 3*5=15, neg=0, hi=0, tag=7 at cycle T.
  - res_valid_o=1 at T+LAT+1, res_data_o=0x0000000F, res_tag_o=7.
- Negate, low half: magnitudes 7 and 6, neg=1, hi=0 -> res_data_o=0xFFFFFFD6; same op with hi=1 -> 0xFFFFFFFF.
- Unsigned high half: 0xFFFFFFFF*0xFFFFFFFF, hi=1 -> 0xFFFFFFFE; lo -> 0x00000001.
- Signed corner: magnitudes 0x80000000 each, neg=0, hi=1 -> 0x40000000.
- Negated zero: 0*5 with neg=1 -> 0 for both halves.
- Credits and backpressure:
  - res_ready_i=0; issue 4 ops back-to-back -> issue_ok_o=0 from the cycle after the 4th.
  - A 5th issue_i -> dropped, err_o=1.
  - Then res_ready_i=1 -> exactly 4 results in issue order; issue_ok_o=1 one cycle after the first pop.
- Flush and reset:
  - Issue 2 ops, assert flush_i at T+3 -> no res_valid_o ever, issue_ok_o=1 at T+4, err_o unchanged.
  - rst_ni low mid-flight -> all outputs 0 immediately, asynchronously.
- Misalignment: force cell_valid_i=1 with no op issued -> err_o=1, FIFO stays empty.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and helpers for the multiplier result back-end.
package mult_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned TAGW = 5;
  localparam int unsigned PW   = 2 * XLEN;

  // Per-op sideband carried alongside the multiplier chain.
  typedef struct packed {
    logic            v;
    logic            neg;
    logic            hi;
    logic [TAGW-1:0] tag;
  } sb_t;

  // Two's-complement negation over the full product width.
  function automatic logic [PW-1:0] twos_neg(input logic [PW-1:0] p);
    return ~p + PW'(1);
  endfunction

endpackage

// File: rtl/mult_post_fifo.sv
// Synchronous first-word fall-through FIFO with flush.
module mult_post_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 37
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q, wr_d, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign data_o  = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Next pointer and occupancy; flush wins over push and pop.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = ptr_inc(wr_q);
      if (do_pop)  rd_d = ptr_inc(rd_q);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Pointer, count and storage registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (do_push && !flush_i) mem_q[wr_q] <= data_i;
    end
  end

endmodule

// File: rtl/mult_post.sv
// Result back-end for the shift-add multiplier chain: sideband delay line,
// sign fix-up, half select, result FIFO and issue credits.
module mult_post
  import mult_pkg::*;
#(
  parameter int unsigned LAT   = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            issue_i,
  input  logic            neg_i,
  input  logic            hi_i,
  input  logic [TAGW-1:0] tag_i,
  output logic            issue_ok_o,
  input  logic            cell_valid_i,
  input  logic [PW:0]     cell_acc_i,
  output logic            res_valid_o,
  input  logic            res_ready_i,
  output logic [XLEN-1:0] res_data_o,
  output logic [TAGW-1:0] res_tag_o,
  output logic            err_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned FW = XLEN + TAGW;

  sb_t             dl_q [LAT];
  sb_t             in_sb, head;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            issue_acc, pop, fifo_empty, fifo_full;
  logic [PW-1:0]   prod, fixed;
  logic [XLEN-1:0] res;
  logic [FW-1:0]   fifo_out;
  logic            unused_acc_msb;

  // Carry bit of the last cell is not part of the product.
  assign unused_acc_msb = cell_acc_i[PW];

  assign issue_ok_o  = (cnt_q < CW'(DEPTH));
  assign issue_acc   = issue_i && issue_ok_o;
  assign res_valid_o = !fifo_empty;
  assign pop         = res_valid_o && res_ready_i;
  assign head        = dl_q[LAT-1];
  assign err_o       = err_q;

  // Stage-0 sideband; a dropped issue enters as an empty slot.
  always_comb begin
    in_sb     = '0;
    in_sb.v   = issue_acc;
    in_sb.neg = neg_i;
    in_sb.hi  = hi_i;
    in_sb.tag = tag_i;
  end

  // Sign fix-up and half select for the op at the head of the delay line.
  always_comb begin
    prod  = cell_acc_i[PW-1:0];
    fixed = head.neg ? twos_neg(prod) : prod;
    res   = head.hi ? fixed[PW-1:XLEN] : fixed[XLEN-1:0];
  end

  // Credit count and sticky protocol error.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q | (issue_i & ~issue_ok_o) | (head.v ^ cell_valid_i);
    if (flush_i) begin
      cnt_d = '0;
    end else if (issue_acc && !pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!issue_acc && pop) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Sideband delay line matched to the chain latency.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(LAT); i++) dl_q[i] <= '0;
    end else begin
      dl_q[0] <= flush_i ? '0 : in_sb;
      for (int i = 1; i < int'(LAT); i++) dl_q[i] <= flush_i ? '0 : dl_q[i-1];
    end
  end

  // Credit and error registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  mult_post_fifo #(
    .DEPTH (DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (head.v),
    .data_i  ({res, head.tag}),
    .pop_i   (pop),
    .data_o  (fifo_out),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign res_data_o = fifo_out[FW-1:TAGW];
  assign res_tag_o  = fifo_out[TAGW-1:0];

  // Full never gates a write: credits bound occupancy to DEPTH.
  logic unused_fifo_full;
  assign unused_fifo_full = fifo_full;

endmodule

// File: tb/tb_mult_post.sv
// Bench for mult_post: emulates the multiplier chain, keeps a queue-based
// model of the result stream, and adds directed literal checks.
module tb_mult_post;
  import mult_pkg::*;

  localparam int LAT   = 32;
  localparam int DEPTH = 4;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            flush_i, issue_i, neg_i, hi_i;
  logic [TAGW-1:0] tag_i;
  logic            issue_ok_o;
  logic            cell_valid_i;
  logic [PW:0]     cell_acc_i;
  logic            res_valid_o, res_ready_i;
  logic [XLEN-1:0] res_data_o;
  logic [TAGW-1:0] res_tag_o;
  logic            err_o;

  mult_post #(.LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .issue_i(issue_i),
    .neg_i(neg_i), .hi_i(hi_i), .tag_i(tag_i), .issue_ok_o(issue_ok_o),
    .cell_valid_i(cell_valid_i), .cell_acc_i(cell_acc_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .res_data_o(res_data_o), .res_tag_o(res_tag_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 0;

  logic [31:0] op_a = '0, op_b = '0;
  logic        force_cv = 1'b0;
  logic        chain_cur_v = 1'b0;
  logic        chain_v   [256];
  logic [PW:0] chain_acc [256];

  assign cell_valid_i = chain_cur_v | force_cv;

  typedef struct { int due; logic [31:0] d; logic [4:0] t; } pend_t;
  typedef struct { logic [31:0] d; logic [4:0] t; } res_t;
  pend_t pend[$];
  res_t  mq[$];
  int    mcnt = 0;
  bit    merr = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Plain-arithmetic result of an op.
  function automatic logic [31:0] expect_res(input logic [31:0] a, input logic [31:0] b,
                                             input logic neg, input logic hi);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    if (neg) p = 64'd0 - p;
    return hi ? p[63:32] : p[31:0];
  endfunction

  // Chain emulation and reference model, advanced on each rising edge.
  always @(posedge clk_i) begin
    bit    head_v, acc, popm;
    pend_t pe;
    res_t  r;
    if (!rst_ni) begin
      for (int i = 0; i < 256; i++) chain_v[i] = 1'b0;
      pend.delete();
      mq.delete();
      mcnt = 0;
      merr = 0;
    end else begin
      head_v = (pend.size() > 0) && (pend[0].due == cyc);
      if (cell_valid_i != head_v) merr = 1;
      if (issue_i && mcnt >= DEPTH) merr = 1;
      if (flush_i) begin
        pend.delete();
        mq.delete();
        mcnt = 0;
        for (int i = 0; i < 256; i++) chain_v[i] = 1'b0;
      end else begin
        acc  = issue_i && (mcnt < DEPTH);
        popm = (mq.size() > 0) && res_ready_i;
        if (popm) void'(mq.pop_front());
        mcnt = mcnt + int'(acc) - int'(popm);
        if (head_v) begin
          pe = pend.pop_front();
          r.d = pe.d;
          r.t = pe.t;
          mq.push_back(r);
        end
        if (acc) begin
          pe.due = cyc + LAT;
          pe.d   = expect_res(op_a, op_b, neg_i, hi_i);
          pe.t   = tag_i;
          pend.push_back(pe);
        end
        if (issue_i) begin
          chain_v[(cyc + LAT) % 256]   = 1'b1;
          chain_acc[(cyc + LAT) % 256] = {1'($urandom), 64'(op_a) * 64'(op_b)};
        end
      end
      chain_v[cyc % 256] = 1'b0;
    end
    cyc++;
  end

  // Present the chain's last-cell output for the current cycle.
  always @(negedge clk_i) begin
    chain_cur_v = chain_v[cyc % 256];
    cell_acc_i  = chain_acc[cyc % 256];
  end

  // Per-cycle comparison of DUT outputs against the model.
  always @(posedge clk_i) begin
    #1;
    if (rst_ni && chk_en) begin
      chk("m_valid", 64'(res_valid_o), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("m_data", 64'(res_data_o), 64'(mq[0].d));
        chk("m_tag", 64'(res_tag_o), 64'(mq[0].t));
      end
      chk("m_issue_ok", 64'(issue_ok_o), 64'(mcnt < DEPTH));
      chk("m_err", 64'(err_o), 64'(merr));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "timeout");
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic neg,
                       input logic hi, input logic [4:0] tag, output int t);
    op_a = a; op_b = b; neg_i = neg; hi_i = hi; tag_i = tag;
    issue_i = 1'b1;
    t = cyc;
    @(negedge clk_i);
    issue_i = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk_i);
  endtask

  task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic neg, input logic hi, input logic [4:0] tag,
                        input logic [31:0] exp);
    int t;
    res_ready_i = 1'b0;
    issue(a, b, neg, hi, tag, t);
    wait_until(t + LAT);
    chk({nm, "_early"}, 64'(res_valid_o), 64'(0));
    @(negedge clk_i);
    chk({nm, "_valid"}, 64'(res_valid_o), 64'(1));
    chk({nm, "_data"}, 64'(res_data_o), 64'(exp));
    chk({nm, "_tag"}, 64'(res_tag_o), 64'(tag));
    res_ready_i = 1'b1;
    @(negedge clk_i);
    res_ready_i = 1'b0;
    chk({nm, "_popped"}, 64'(res_valid_o), 64'(0));
  endtask

  logic [31:0] cr_exp [4];
  int t0, c0;

  initial begin
    cr_exp[0] = 32'h0000_0100;
    cr_exp[1] = 32'hFFFF_FE00;
    cr_exp[2] = 32'h0000_0300;
    cr_exp[3] = 32'hFFFF_FC00;

    rst_ni = 1'b0; flush_i = 1'b0; issue_i = 1'b0; neg_i = 1'b0; hi_i = 1'b0;
    tag_i = '0; res_ready_i = 1'b0;
    #1;
    chk("rst_valid", 64'(res_valid_o), 64'(0));
    chk("rst_data", 64'(res_data_o), 64'(0));
    chk("rst_tag", 64'(res_tag_o), 64'(0));
    chk("rst_issue_ok", 64'(issue_ok_o), 64'(1));
    chk("rst_err", 64'(err_o), 64'(0));
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    chk_en = 1;
    @(negedge clk_i);

    // Directed result-path vectors.
    run_op("basic",    32'd3,          32'd5,          1'b0, 1'b0, 5'd7,  32'h0000_000F);
    run_op("neg_lo",   32'd7,          32'd6,          1'b1, 1'b0, 5'd3,  32'hFFFF_FFD6);
    run_op("neg_hi",   32'd7,          32'd6,          1'b1, 1'b1, 5'd4,  32'hFFFF_FFFF);
    run_op("uns_hi",   32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 1'b1, 5'd5,  32'hFFFF_FFFE);
    run_op("uns_lo",   32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 1'b0, 5'd6,  32'h0000_0001);
    run_op("min_hi",   32'h8000_0000,  32'h8000_0000,  1'b0, 1'b1, 5'd8,  32'h4000_0000);
    run_op("negz_lo",  32'd0,          32'd5,          1'b1, 1'b0, 5'd9,  32'h0000_0000);
    run_op("negz_hi",  32'd0,          32'd5,          1'b1, 1'b1, 5'd10, 32'h0000_0000);

    // Head-less cell valid: error, nothing written.
    force_cv = 1'b1;
    @(negedge clk_i);
    force_cv = 1'b0;
    chk("mis_err", 64'(err_o), 64'(1));
    repeat (3) @(negedge clk_i);
    chk("mis_empty", 64'(res_valid_o), 64'(0));

    // Asynchronous reset with a buffered result and err set.
    res_ready_i = 1'b0;
    issue(32'd3, 32'd5, 1'b0, 1'b0, 5'd12, t0);
    wait_until(t0 + LAT + 1);
    chk("pre_rst_valid", 64'(res_valid_o), 64'(1));
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_valid", 64'(res_valid_o), 64'(0));
    chk("arst_data", 64'(res_data_o), 64'(0));
    chk("arst_tag", 64'(res_tag_o), 64'(0));
    chk("arst_err", 64'(err_o), 64'(0));
    chk("arst_issue_ok", 64'(issue_ok_o), 64'(1));
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Credits: fill with four ops while the consumer stalls.
    res_ready_i = 1'b0;
    c0 = cyc;
    for (int k = 0; k < 4; k++) begin
      chk("cr_ok_before", 64'(issue_ok_o), 64'(1));
      op_a = 32'(k + 1); op_b = 32'h100; neg_i = 1'(k % 2); hi_i = 1'b0;
      tag_i = 5'(k + 1);
      issue_i = 1'b1;
      @(negedge clk_i);
    end
    chk("cr_ok_full", 64'(issue_ok_o), 64'(0));
    op_a = 32'd9; op_b = 32'd9; tag_i = 5'd5;
    @(negedge clk_i);
    issue_i = 1'b0;
    chk("cr_drop_err", 64'(err_o), 64'(1));
    wait_until(c0 + LAT + 6);
    chk("cr_buffered", 64'(res_valid_o), 64'(1));
    chk("cr_ok_still0", 64'(issue_ok_o), 64'(0));
    res_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("cr_valid", 64'(res_valid_o), 64'(1));
      chk("cr_tag", 64'(res_tag_o), 64'(k + 1));
      chk("cr_data", 64'(res_data_o), 64'(cr_exp[k]));
      chk("cr_ok", 64'(issue_ok_o), 64'(k != 0));
      @(negedge clk_i);
    end
    chk("cr_drained", 64'(res_valid_o), 64'(0));
    res_ready_i = 1'b0;

    // Flush two in-flight ops; err stays set.
    issue(32'd2, 32'd2, 1'b0, 1'b0, 5'd10, t0);
    issue(32'd4, 32'd4, 1'b0, 1'b0, 5'd11, c0);
    wait_until(t0 + 3);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    chk("fl_issue_ok", 64'(issue_ok_o), 64'(1));
    chk("fl_valid", 64'(res_valid_o), 64'(0));
    chk("fl_err", 64'(err_o), 64'(1));
    res_ready_i = 1'b1;
    for (int k = 0; k < LAT + 4; k++) begin
      @(negedge clk_i);
      if (res_valid_o !== 1'b0) chk("fl_never_valid", 64'(res_valid_o), 64'(0));
    end
    chk("fl_end_valid", 64'(res_valid_o), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
